// File: rtl/load_unit.sv
// Load unit: fetches one or two aligned words for a byte/half/word load,
// then shifts and extends the result into data_out with a one-cycle data_valid.
module load_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [2:0]  funct3,
  output logic        data_valid,
  output logic [31:0] data_out,
  output logic        err,
  output logic        mem_read,
  output logic [31:0] mem_address,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  typedef enum logic [2:0] {
    LF_LB  = 3'b000,
    LF_LH  = 3'b001,
    LF_LW  = 3'b010,
    LF_LBU = 3'b100,
    LF_LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [1:0] {S_IDLE, S_RD0, S_RD1, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_addr;
  logic [2:0]  r_f3;
  logic [31:0] r_lo;
  logic [31:0] r_data_out;
  logic        r_err;
  logic [63:0] w_dword;
  logic [31:0] w_fmt;

  function automatic logic is_legal(input logic [2:0] f3);
    case (f3)
      LF_LB, LF_LH, LF_LW, LF_LBU, LF_LHU: is_legal = 1'b1;
      default:                             is_legal = 1'b0;
    endcase
  endfunction

  // A load is split when its bytes cross into the next aligned word.
  function automatic logic is_split(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      LF_LW:         is_split = (off != 2'b00);
      LF_LH, LF_LHU: is_split = (off == 2'b11);
      default:       is_split = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] format_load(input logic [63:0] dw,
                                              input logic [1:0]  off,
                                              input logic [2:0]  f3);
    logic [31:0] sh;
    sh = 32'(dw >> {off, 3'b000});
    case (f3)
      LF_LB:   format_load = {{24{sh[7]}}, sh[7:0]};
      LF_LBU:  format_load = {24'h000000, sh[7:0]};
      LF_LH:   format_load = {{16{sh[15]}}, sh[15:0]};
      LF_LHU:  format_load = {16'h0000, sh[15:0]};
      LF_LW:   format_load = sh;
      default: format_load = 32'h0000_0000;
    endcase
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state selection.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_next = is_legal(funct3) ? S_RD0 : S_DONE;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_RD0: begin
        if (mem_resp) begin
          w_next = is_split(r_f3, r_addr[1:0]) ? S_RD1 : S_DONE;
        end else begin
          w_next = S_RD0;
        end
      end
      S_RD1: begin
        if (mem_resp) begin
          w_next = S_DONE;
        end else begin
          w_next = S_RD1;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // The final word arrives on mem_rdata, so it is formatted before being stored.
  always_comb begin
    w_dword = {32'h0000_0000, mem_rdata};
    if (r_state == S_RD1) begin
      w_dword = {mem_rdata, r_lo};
    end else begin
      w_dword = {32'h0000_0000, mem_rdata};
    end
    w_fmt = format_load(w_dword, r_addr[1:0], r_f3);
  end

  // Request latch, low-word buffer and registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= 32'h0000_0000;
      r_f3       <= 3'b000;
      r_lo       <= 32'h0000_0000;
      r_data_out <= 32'h0000_0000;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_addr <= req_addr;
            r_f3   <= funct3;
            r_lo   <= 32'h0000_0000;
            if (!is_legal(funct3)) begin
              r_data_out <= 32'h0000_0000;
              r_err      <= 1'b1;
            end
          end
        end
        S_RD0: begin
          if (mem_resp) begin
            r_lo <= mem_rdata;
            if (!is_split(r_f3, r_addr[1:0])) begin
              r_data_out <= w_fmt;
              r_err      <= 1'b0;
            end
          end
        end
        S_RD1: begin
          if (mem_resp) begin
            r_data_out <= w_fmt;
            r_err      <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Memory-side address decode; RD1 wraps naturally at 2^32.
  always_comb begin
    mem_address = 32'h0000_0000;
    case (r_state)
      S_RD0:   mem_address = {r_addr[31:2], 2'b00};
      S_RD1:   mem_address = {r_addr[31:2], 2'b00} + 32'h0000_0004;
      default: mem_address = 32'h0000_0000;
    endcase
  end

  assign mem_read   = (r_state == S_RD0) || (r_state == S_RD1);
  assign req_ready  = (r_state == S_IDLE);
  assign data_valid = (r_state == S_DONE);
  assign data_out   = r_data_out;
  assign err        = r_err;

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit: hand-computed load vectors, split/wrap cases,
// memory wait states, illegal funct3 and asynchronous reset mid-access.
module tb_load_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  funct3;
  logic        data_valid;
  logic [31:0] data_out;
  logic        err;
  logic        mem_read;
  logic [31:0] mem_address;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  int checks;
  int errors;
  int cyc;

  load_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .funct3      (funct3),
    .data_valid  (data_valid),
    .data_out    (data_out),
    .err         (err),
    .mem_read    (mem_read),
    .mem_address (mem_address),
    .mem_rdata   (mem_rdata),
    .mem_resp    (mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Serve one read phase: hold for 'waits' cycles, then respond with 'word'.
  task automatic serve(input string tag, input logic [31:0] exp_addr,
                       input logic [31:0] word, input int waits);
    for (int i = 0; i < waits; i++) begin
      check({tag, "_rd_wait"}, {31'h0, mem_read}, 32'h1);
      check({tag, "_addr_wait"}, mem_address, exp_addr);
      step();
    end
    check({tag, "_rd"}, {31'h0, mem_read}, 32'h1);
    check({tag, "_addr"}, mem_address, exp_addr);
    check({tag, "_busy"}, {31'h0, req_ready}, 32'h0);
    mem_rdata = word;
    mem_resp  = 1'b1;
    step();
    mem_resp  = 1'b0;
    mem_rdata = 32'hDEAD_0000;
  endtask

  task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] lo, input logic [31:0] hi,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input int nphase, input int waits,
                         input logic [31:0] exp_data, input logic exp_err, input int exp_lat);
    check({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1;
    req_addr  = addr;
    funct3    = f3;
    cyc = 0;
    step();
    req_valid = 1'b0;
    req_addr  = 32'h0000_0000;
    if (nphase >= 1) serve({tag, "_p0"}, a0, lo, waits);
    if (nphase >= 2) serve({tag, "_p1"}, a1, hi, 0);
    check({tag, "_dv"}, {31'h0, data_valid}, 32'h1);
    check({tag, "_lat"}, cyc, exp_lat);
    check({tag, "_data"}, data_out, exp_data);
    check({tag, "_err"}, {31'h0, err}, {31'h0, exp_err});
    check({tag, "_rd_done"}, {31'h0, mem_read}, 32'h0);
    step();
    check({tag, "_dv_off"}, {31'h0, data_valid}, 32'h0);
    check({tag, "_hold"}, data_out, exp_data);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = 32'h0000_0000;
    funct3    = 3'b000;
    mem_rdata = 32'h0000_0000;
    mem_resp  = 1'b0;
    #12;
    check("rst_ready", {31'h0, req_ready}, 32'h1);
    check("rst_rd", {31'h0, mem_read}, 32'h0);
    check("rst_addr", mem_address, 32'h0000_0000);
    check("rst_dv", {31'h0, data_valid}, 32'h0);
    check("rst_data", data_out, 32'h0000_0000);
    check("rst_err", {31'h0, err}, 32'h0);
    rst_n = 1'b1;
    step();

    do_load("lb",    32'h0000_1003, 3'b000, 32'h8012_3456, 32'h0, 32'h0000_1000, 32'h0, 1, 0, 32'hFFFF_FF80, 1'b0, 2);
    do_load("lbpos", 32'h0000_1000, 3'b000, 32'h0000_007F, 32'h0, 32'h0000_1000, 32'h0, 1, 0, 32'h0000_007F, 1'b0, 2);
    do_load("lhu",   32'h0000_1002, 3'b101, 32'hBEEF_1234, 32'h0, 32'h0000_1000, 32'h0, 1, 0, 32'h0000_BEEF, 1'b0, 2);
    do_load("lh",    32'h0000_1002, 3'b001, 32'hBEEF_1234, 32'h0, 32'h0000_1000, 32'h0, 1, 0, 32'hFFFF_BEEF, 1'b0, 2);
    do_load("lwspl", 32'h0000_1001, 3'b010, 32'h4433_2211, 32'h8877_6655, 32'h0000_1000, 32'h0000_1004, 2, 0, 32'h5544_3322, 1'b0, 3);
    do_load("lhwrap",32'hFFFF_FFFF, 3'b001, 32'hAB00_0000, 32'h0000_00CD, 32'hFFFF_FFFC, 32'h0000_0000, 2, 0, 32'hFFFF_CDAB, 1'b0, 3);
    do_load("lhuspl",32'h0000_2003, 3'b101, 32'h7F00_0000, 32'h0000_00FE, 32'h0000_2000, 32'h0000_2004, 2, 0, 32'h0000_FE7F, 1'b0, 3);
    do_load("lwwait",32'h0000_2000, 3'b010, 32'hDEAD_BEEF, 32'h0, 32'h0000_2000, 32'h0, 1, 3, 32'hDEAD_BEEF, 1'b0, 5);

    // mem_resp in IDLE must not start anything
    mem_resp = 1'b1;
    step();
    mem_resp = 1'b0;
    check("idle_resp_ready", {31'h0, req_ready}, 32'h1);
    check("idle_resp_dv", {31'h0, data_valid}, 32'h0);
    check("idle_resp_rd", {31'h0, mem_read}, 32'h0);

    // illegal funct3: completes in cycle 1 without touching memory
    do_load("illeg", 32'h0000_1000, 3'b011, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0000_0000, 1'b1, 1);
    check("illeg_err_hold", {31'h0, err}, 32'h1);
    do_load("after", 32'h0000_1004, 3'b010, 32'h1234_5678, 32'h0, 32'h0000_1004, 32'h0, 1, 0, 32'h1234_5678, 1'b0, 2);

    // reset while in RD1 of a split lw
    req_valid = 1'b1;
    req_addr  = 32'h0000_1002;
    funct3    = 3'b010;
    step();
    req_valid = 1'b0;
    serve("rstmid_p0", 32'h0000_1000, 32'h1111_1111, 0);
    check("rstmid_in_rd1", mem_address, 32'h0000_1004);
    rst_n = 1'b0;
    #1;
    check("rstmid_rd", {31'h0, mem_read}, 32'h0);
    check("rstmid_ready", {31'h0, req_ready}, 32'h1);
    check("rstmid_data", data_out, 32'h0000_0000);
    mem_resp = 1'b1;
    step();
    mem_resp = 1'b0;
    check("rstmid_dv", {31'h0, data_valid}, 32'h0);
    rst_n = 1'b1;
    step();
    check("rstmid_dv2", {31'h0, data_valid}, 32'h0);
    do_load("lbu", 32'h0000_3000, 3'b100, 32'h1234_56F0, 32'h0, 32'h0000_3000, 32'h0, 1, 0, 32'h0000_00F0, 1'b0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_unit.md
LOAD_UNIT -- requirements
Module: load_unit

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, listed first as `clk` (input, 1, rising-edge clock) and `rst_n` (input, 1, asynchronous active-low reset).
REQ-002 SHALL have these request-side ports:
- `req_valid`  input  1 -- load request present.
- `req_ready`  output 1 -- unit can accept a request.
- `req_addr`  input  32 -- byte address of the load.
- `funct3`  input  3 -- load type (load_funct3_t): lb=000, lh=001, lw=010, lbu=100, lhu=101.
- `data_valid`  output 1 -- one-cycle completion pulse.
- `data_out`  output 32 -- formatted load result.
- `err`  output 1 -- completion carried an illegal funct3; valid with `data_valid`.
REQ-003 SHALL have these memory-side ports:
- `mem_read`  output 1 -- read strobe, held until `mem_resp`.
- `mem_address`  output 32 -- word-aligned read address.
- `mem_rdata`  input 32 -- read data, valid with `mem_resp`.
- `mem_resp`  input 1 -- read complete.

Function
REQ-004 SHALL implement the states IDLE, RD0, RD1 and DONE.
REQ-005 IDLE: `req_ready`=1; a request is accepted when `req_valid`=1 at a rising edge.
- On acceptance: latch `req_addr` and `funct3`.
- Legal funct3: go to RD0. Illegal funct3: go to DONE with `err`=1 and no memory access.
REQ-006 SHALL hold `req_ready`=0 outside IDLE and ignore `req_valid` there.
REQ-007 RD0: `mem_read`=1 and `mem_address`={addr[31:2],2'b00}, both held stable until `mem_resp`=1.
- On `mem_resp`: capture `mem_rdata` as the low word.
- Split access: go to RD1. Otherwise: go to DONE.
REQ-008 Split access: lw with addr[1:0]≠00, or lh/lhu with addr[1:0]=11; no other case is split.
REQ-009 RD1: `mem_read`=1 and `mem_address`=low word address+4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
- On `mem_resp`: capture the high word and go to DONE.
- `mem_read` stays asserted across the RD0->RD1 transition; only the address changes.
REQ-010 DONE: `data_valid`=1 for exactly one cycle, then return to IDLE; `mem_read`=0.
REQ-011 Formatting: form the 64-bit value {high,low}, with high=0 when the access is not split, and shift it right by addr[1:0]*8.
- lb: sign-extend bits [7:0]. lbu: zero-extend bits [7:0].
- lh: sign-extend bits [15:0]. lhu: zero-extend bits [15:0].
- lw: bits [31:0].
REQ-012 `data_out` and `err` SHALL be registered on the transition into DONE and hold until the next completion.
- `data_out` SHALL be 0 on an illegal-funct3 completion.
REQ-013 Latency, counted from the acceptance edge:
- Zero-wait memory, non-split: `data_valid` in cycle 2.
- Each memory wait cycle adds one cycle.
- A split access adds one read phase.
REQ-014 `mem_resp` SHALL be ignored in IDLE and DONE.
REQ-015 `mem_rdata` SHALL be sampled only in a cycle where `mem_resp`=1 in RD0 or RD1.
REQ-016 The memory interface is read-only; the unit SHALL never issue a write.

Reset
REQ-017 While `rst_n`=0, the following SHALL be forced immediately, independent of `clk`:
- state=IDLE, `req_ready`=1, `mem_read`=0, `mem_address`=0.
- `data_valid`=0, `data_out`=0, `err`=0.
- Latched address, funct3 and word buffers = 0.
REQ-018 Reset during RD0, RD1 or DONE SHALL abort the access with no `data_valid` pulse.
REQ-019 After reset, the first request SHALL behave identically to the first request after power-up.

Verification
REQ-020 lb, addr 0x1003, `mem_rdata`=0x80123456 with zero wait -> single read at 0x1000; `data_valid` in cycle 2; `data_out`=0xFFFFFF80.
REQ-021 lhu, addr 0x1002, `mem_rdata`=0xBEEF1234 -> `data_out`=0x0000BEEF; lh at the same address and data -> 0xFFFFBEEF.
REQ-022 lw, addr 0x1001, words 0x44332211@0x1000 and 0x88776655@0x1004 -> two reads in order; `mem_read` continuous; `data_out`=0x55443322.
REQ-023 lh, addr 0xFFFFFFFF, words 0xAB000000@0xFFFFFFFC and 0x000000CD@0x00000000 -> second address wraps to 0; `data_out`=0xFFFFCDAB.
REQ-024 lw, addr 0x2000, `mem_resp` delayed 3 cycles -> `mem_address` stable at 0x2000 and `mem_read`=1 for 4 cycles; `data_valid` in cycle 5.
- Then: `rst_n` pulsed low in RD1 of a split lw -> `mem_read`=0 at once; no `data_valid`.
- A following lbu at 0x3000 completes normally.
REQ-025 funct3=011 -> no `mem_read`; `data_valid`=1 and `err`=1 in cycle 1; `data_out`=0.
- A subsequent legal load -> `err`=0.
